dpr_cmd_issuer: RTL
===================

DPR_CMD_ISSUER -- requirements
Module: dpr_cmd_issuer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the region pointer width.
REQ-002 The block SHALL have parameter OPC_W, default 4, the layer opcode width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-004 Port: layer_valid  input  1  host layer descriptor valid.
REQ-005 Port: layer_ready  output  1  descriptor accepted when layer_valid && layer_ready at a clk edge.
REQ-006 Port: layer_opcode  input  OPC_W  layer opcode (LINEAR, RELU, SOFTMAX, ...).
REQ-007 Port: layer_last  input  1  descriptor is the model's final layer.
REQ-008 Port: layer_regions  input  12*ADDR_W  {scratch, sgrad, weight, wgrad, bias, bgrad} as begin/end pairs, scratch_begin in the MSBs.
REQ-009 Port: run_valid / run_ready  input / output  1  inference-run handshake.
REQ-010 Port: run_regions  input  4*ADDR_W  {in_begin, in_end, out_begin, out_end}, in_begin in the MSBs.
REQ-011 Port: mm_o  output  4  model-manager command: WAIT=0, ASN_MODEL=1, ASN_LAYER=2, ASN_SCRATCH=3, ASN_SGRAD=4, ASN_WEIGHT=5, ASN_WGRAD=6, ASN_BIAS=7, ASN_BGRAD=8, ASN_INPUT=9, ASN_OUTPUT=10.
REQ-012 Port: asn_opcode  output  OPC_W  opcode of the layer being assigned.
REQ-013 Port: pass_begin / pass_end  output  ADDR_W  dpr_pass region pointer.
REQ-014 Port: model_loaded  output  1  complete model issued, no load in progress.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States: IDLE, M_START, L_LAYER, L_SCR, L_SGR, L_WT, L_WG, L_B, L_BG, L_CLOSE, L_WAIT, R_IN, R_OUT, R_PTR.
REQ-017 Pointer rule: the region for command X SHALL appear on pass_begin/pass_end in the cycle immediately after mm_o==X; pass_* SHALL be 0 in all other cycles.
REQ-018 layer_ready SHALL be 1 only in IDLE, L_CLOSE and L_WAIT; run_ready SHALL be 1 only in IDLE with model_loaded=1 and layer_valid=0.
REQ-019 An accepted descriptor SHALL be captured in internal registers; inputs are don't-care afterwards.
REQ-020 IDLE: mm_o=WAIT. Layer accept -> M_START, model_loaded cleared. Otherwise run accept -> R_IN. Layer has priority when both are valid.
REQ-021 M_START: mm_o=ASN_MODEL -> L_LAYER.
REQ-022 L_LAYER: mm_o=ASN_LAYER, asn_opcode=captured opcode, held until the next ASN_LAYER or reset.
REQ-023 L_SCR..L_BG SHALL emit ASN_SCRATCH..ASN_BGRAD in order, one per cycle, each carrying the previous command's pointer per REQ-017.
REQ-024 L_CLOSE: mm_o=ASN_MODEL carrying the bgrad pointer.
REQ-025 Exit from L_CLOSE: if the current layer was last -> IDLE with model_loaded=1; else on layer accept -> L_LAYER; else -> L_WAIT.
REQ-026 L_WAIT: mm_o=WAIT; on layer accept -> L_LAYER.
REQ-027 R_IN: mm_o=ASN_INPUT.
REQ-028 R_OUT: mm_o=ASN_OUTPUT, pass=input region.
REQ-029 R_PTR: mm_o=WAIT, pass=output region -> IDLE; model_loaded stays 1.
REQ-030 Timing: a layer accepted in IDLE at edge t SHALL give ASN_MODEL at t+1, ASN_LAYER at t+2 and BGRAD at t+8; ASN_MODEL (bgrad pointer) at t+9.
REQ-031 layer_last on a mid-load descriptor SHALL end the model after that layer; no maximum layer count.

Reset
REQ-032 While rst=1 at a clk edge, state SHALL become IDLE and every output SHALL become 0 (mm_o=WAIT, model_loaded=0, ready signals 0 in that cycle).
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence; no further non-WAIT command is emitted until a new handshake.

Verification
REQ-034 One layer: LINEAR, last=1, scratch 42..50, sgrad 50..58, weight 5..34, wgrad 58..87, bias 34..42, bgrad 87..95 -> MODEL, LAYER, SCRATCH, SGRAD(42,50), WEIGHT(50,58), WGRAD(5,34), BIAS(58,87), BGRAD(34,42), MODEL(87,95), WAIT(0,0); model_loaded=1.
REQ-035 Two layers, second (RELU, last=1) valid during L_CLOSE -> ASN_MODEL immediately followed by ASN_LAYER with asn_opcode=RELU; no WAIT between.
REQ-036 Second layer delayed 5 cycles -> five WAIT cycles in L_WAIT, then ASN_LAYER; model_loaded stays 0 throughout.
REQ-037 Run with in 0x80000000..0x80000007, out 0x80000007..0x8000000E -> INPUT, OUTPUT(in pair), WAIT(out pair); run_ready=0 before any model is loaded.
REQ-038 Layer and run both valid in IDLE -> layer accepted; model_loaded drops to 0 and the run waits.
REQ-039 rst=1 during L_WT -> next cycle mm_o=WAIT, pass=0, model_loaded=0; a subsequent layer restarts at ASN_MODEL.

Source files
------------

// File: rtl/dpr_cmd_issuer.sv
// dpr_cmd_issuer: turns host layer descriptors and inference-run requests into the
// model-manager command stream (mm_o) together with the dpr_pass region pointer.
//
// A model load is one ASN_MODEL opener, then per layer ASN_LAYER followed by the six
// region commands SCRATCH..BGRAD, then an ASN_MODEL close. Layers chain back-to-back
// when the next descriptor is offered during the close cycle. A run is ASN_INPUT,
// ASN_OUTPUT, WAIT. Each region pointer shows up on pass_begin/pass_end one cycle
// after the command that names it, and pass_* is zero in every other cycle.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   layer_valid      host layer descriptor valid
//   layer_ready      descriptor accepted on layer_valid && layer_ready at a clk edge
//   layer_opcode     layer opcode
//   layer_last       descriptor is the final layer of the model
//   layer_regions    {scratch, sgrad, weight, wgrad, bias, bgrad} begin/end pairs,
//                    scratch_begin in the MSBs
//   run_valid        inference-run request valid
//   run_ready        run accepted on run_valid && run_ready at a clk edge
//   run_regions      {in_begin, in_end, out_begin, out_end}, in_begin in the MSBs
//   mm_o             model-manager command
//   asn_opcode       opcode of the layer most recently assigned
//   pass_begin/end   region pointer for the previous cycle's command
//   model_loaded     complete model issued and no load in progress
// Every output is driven straight from a register.

module dpr_cmd_issuer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OPC_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  layer_valid,
    output logic                  layer_ready,
    input  logic [OPC_W-1:0]      layer_opcode,
    input  logic                  layer_last,
    input  logic [12*ADDR_W-1:0]  layer_regions,
    input  logic                  run_valid,
    output logic                  run_ready,
    input  logic [4*ADDR_W-1:0]   run_regions,
    output logic [3:0]            mm_o,
    output logic [OPC_W-1:0]      asn_opcode,
    output logic [ADDR_W-1:0]     pass_begin,
    output logic [ADDR_W-1:0]     pass_end,
    output logic                  model_loaded
);

    // Model-manager command encoding
    localparam logic [3:0] MmWait       = 4'd0;
    localparam logic [3:0] MmAsnModel   = 4'd1;
    localparam logic [3:0] MmAsnLayer   = 4'd2;
    localparam logic [3:0] MmAsnScratch = 4'd3;
    localparam logic [3:0] MmAsnSgrad   = 4'd4;
    localparam logic [3:0] MmAsnWeight  = 4'd5;
    localparam logic [3:0] MmAsnWgrad   = 4'd6;
    localparam logic [3:0] MmAsnBias    = 4'd7;
    localparam logic [3:0] MmAsnBgrad   = 4'd8;
    localparam logic [3:0] MmAsnInput   = 4'd9;
    localparam logic [3:0] MmAsnOutput  = 4'd10;

    // The state names the command being shown on mm_o in the same cycle.
    typedef enum logic [3:0] {
        StIdle,
        StMStart,
        StLLayer,
        StLScr,
        StLSgr,
        StLWt,
        StLWg,
        StLB,
        StLBg,
        StLClose,
        StLWait,
        StRIn,
        StROut,
        StRPtr
    } state_e;

    state_e state_q, state_d;

    // Captured descriptor / run request
    logic [12*ADDR_W-1:0] lregs_q, lregs_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic                 last_q, last_d;
    logic [4*ADDR_W-1:0]  rregs_q, rregs_d;

    // Output registers
    logic [3:0]        mm_q, mm_d;
    logic [OPC_W-1:0]  asn_opc_q, asn_opc_d;
    logic [ADDR_W-1:0] pass_b_q, pass_b_d;
    logic [ADDR_W-1:0] pass_e_q, pass_e_d;
    logic              loaded_q, loaded_d;
    logic              layer_ready_q, layer_ready_d;
    logic              run_ready_q, run_ready_d;

    logic layer_acc;
    logic run_acc;

    // Handshakes use the registered ready values the host actually sees. Both ready
    // signals can only be high in StIdle; a layer wins over a simultaneous run.
    assign layer_acc = layer_valid & layer_ready_q;
    assign run_acc   = run_valid & run_ready_q & ~layer_acc;

    function automatic logic [3:0] cmd_of(input state_e s);
        logic [3:0] c;
        c = MmWait;
        unique case (s)
            StMStart: c = MmAsnModel;
            StLLayer: c = MmAsnLayer;
            StLScr:   c = MmAsnScratch;
            StLSgr:   c = MmAsnSgrad;
            StLWt:    c = MmAsnWeight;
            StLWg:    c = MmAsnWgrad;
            StLB:     c = MmAsnBias;
            StLBg:    c = MmAsnBgrad;
            StLClose: c = MmAsnModel;
            StRIn:    c = MmAsnInput;
            StROut:   c = MmAsnOutput;
            default:  c = MmWait;
        endcase
        return c;
    endfunction

    // Next-state and capture
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        lregs_d  = lregs_q;
        opc_d    = opc_q;
        last_d   = last_q;
        rregs_d  = rregs_q;

        unique case (state_q)
            StIdle: begin
                if (layer_acc) begin
                    state_d  = StMStart;
                    loaded_d = 1'b0;
                end else if (run_acc) begin
                    state_d = StRIn;
                end
            end
            StMStart: state_d = StLLayer;
            StLLayer: state_d = StLScr;
            StLScr:   state_d = StLSgr;
            StLSgr:   state_d = StLWt;
            StLWt:    state_d = StLWg;
            StLWg:    state_d = StLB;
            StLB:     state_d = StLBg;
            StLBg:    state_d = StLClose;
            StLClose: begin
                if (last_q) begin
                    state_d  = StIdle;
                    loaded_d = 1'b1;
                end else if (layer_acc) begin
                    state_d = StLLayer;
                end else begin
                    state_d = StLWait;
                end
            end
            StLWait: begin
                if (layer_acc) begin
                    state_d = StLLayer;
                end
            end
            StRIn:   state_d = StROut;
            StROut:  state_d = StRPtr;
            StRPtr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (layer_acc) begin
            lregs_d = layer_regions;
            opc_d   = layer_opcode;
            last_d  = layer_last;
        end
        if (run_acc) begin
            rregs_d = run_regions;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_comb begin
        mm_d = cmd_of(state_d);

        // The close of the final layer always returns to idle, so no descriptor is
        // taken there.
        layer_ready_d = (state_d == StIdle) || (state_d == StLWait) ||
                        ((state_d == StLClose) && !last_q);

        // Registered, so it reflects layer_valid from the cycle before.
        run_ready_d = (state_d == StIdle) && loaded_d && !layer_valid;

        asn_opc_d = asn_opc_q;
        if (state_d == StLLayer) begin
            asn_opc_d = opc_d;
        end

        // The pointer follows the command one cycle later: pick the region of the
        // command shown this cycle.
        pass_b_d = '0;
        pass_e_d = '0;
        unique case (state_q)
            StLScr: begin
                pass_b_d = lregs_q[12*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[11*ADDR_W-1 -: ADDR_W];
            end
            StLSgr: begin
                pass_b_d = lregs_q[10*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[9*ADDR_W-1 -: ADDR_W];
            end
            StLWt: begin
                pass_b_d = lregs_q[8*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[7*ADDR_W-1 -: ADDR_W];
            end
            StLWg: begin
                pass_b_d = lregs_q[6*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[5*ADDR_W-1 -: ADDR_W];
            end
            StLB: begin
                pass_b_d = lregs_q[4*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[3*ADDR_W-1 -: ADDR_W];
            end
            StLBg: begin
                pass_b_d = lregs_q[2*ADDR_W-1 -: ADDR_W];
                pass_e_d = lregs_q[ADDR_W-1:0];
            end
            StRIn: begin
                pass_b_d = rregs_q[4*ADDR_W-1 -: ADDR_W];
                pass_e_d = rregs_q[3*ADDR_W-1 -: ADDR_W];
            end
            StROut: begin
                pass_b_d = rregs_q[2*ADDR_W-1 -: ADDR_W];
                pass_e_d = rregs_q[ADDR_W-1:0];
            end
            default: begin
                pass_b_d = '0;
                pass_e_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            lregs_q       <= '0;
            opc_q         <= '0;
            last_q        <= 1'b0;
            rregs_q       <= '0;
            mm_q          <= MmWait;
            asn_opc_q     <= '0;
            pass_b_q      <= '0;
            pass_e_q      <= '0;
            loaded_q      <= 1'b0;
            layer_ready_q <= 1'b0;
            run_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lregs_q       <= lregs_d;
            opc_q         <= opc_d;
            last_q        <= last_d;
            rregs_q       <= rregs_d;
            mm_q          <= mm_d;
            asn_opc_q     <= asn_opc_d;
            pass_b_q      <= pass_b_d;
            pass_e_q      <= pass_e_d;
            loaded_q      <= loaded_d;
            layer_ready_q <= layer_ready_d;
            run_ready_q   <= run_ready_d;
        end
    end

    assign mm_o         = mm_q;
    assign asn_opcode   = asn_opc_q;
    assign pass_begin   = pass_b_q;
    assign pass_end     = pass_e_q;
    assign model_loaded = loaded_q;
    assign layer_ready  = layer_ready_q;
    assign run_ready    = run_ready_q;

endmodule
